imm_extend_unit: RTL and testbench

IMM_EXTEND_UNIT -- requirements
Module: imm_extend_unit

---
 rtl/imm_extend_unit_pkg.sv | 19 +
 rtl/imm_extend_unit_if.sv | 29 ++
 rtl/imm_extend_unit_imm_gen.sv | 25 ++
 rtl/imm_extend_unit.sv | 109 ++++++++++
 tb/tb_imm_extend_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/imm_extend_unit_pkg.sv
// Shared definitions for the immediate-extension unit.
//   imm_src_t    : 2-bit immediate-type code produced by the decoder
//   IMM_I/S/B/J  : encodings of imm_src_t
//   imm_entry_t  : one buffered result (extended immediate plus its type)
package imm_extend_unit_pkg;

  typedef logic [1:0] imm_src_t;

  localparam imm_src_t IMM_I = 2'b00;
  localparam imm_src_t IMM_S = 2'b01;
  localparam imm_src_t IMM_B = 2'b10;
  localparam imm_src_t IMM_J = 2'b11;

  typedef struct packed {
    logic [31:0] ext;
    imm_src_t    kind;
  } imm_entry_t;

endpackage

// File: rtl/imm_extend_unit_if.sv
// Bundle of the upstream and downstream handshakes of imm_extend_unit.
//   in_valid/in_ready/instr/imm_src        : upstream instruction stream
//   out_valid/out_ready/imm_ext/imm_kind   : downstream immediate stream
// Modports:
//   master : the environment (drives instructions, consumes immediates)
//   slave  : the imm_extend_unit itself
interface imm_extend_unit_if;
  import imm_extend_unit_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  imm_src_t    imm_src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_ext;
  imm_src_t    imm_kind;

  modport master (
    output in_valid, instr, imm_src, out_ready,
    input  in_ready, out_valid, imm_ext, imm_kind
  );

  modport slave (
    input  in_valid, instr, imm_src, out_ready,
    output in_ready, out_valid, imm_ext, imm_kind
  );

endinterface

// File: rtl/imm_extend_unit_imm_gen.sv
// Combinational RV32 immediate generator.
//   instr_i   : raw instruction word
//   imm_src_i : immediate type (I, S, B, J)
//   imm_ext_o : sign-extended 32-bit immediate
module imm_gen
  import imm_extend_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  input  imm_src_t    imm_src_i,
  output logic [31:0] imm_ext_o
);

  always_comb begin
    imm_ext_o = '0;
    unique case (imm_src_i)
      IMM_I: imm_ext_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_ext_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_ext_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
      IMM_J: imm_ext_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Immediate-extension unit: extends the immediate of each accepted instruction
// and queues the result in a small circular FIFO for the downstream consumer.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : imm_extend_unit_if.slave (upstream and downstream handshakes)
//   imm_count  : number of accepted entries, saturating at 0xFFFF
//                (present only when IMM_EXTEND_STATS_EN is defined)
// DEPTH must be a power of two, 2 or greater.
module imm_extend_unit
  import imm_extend_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  imm_extend_unit_if.slave   bus
`ifdef IMM_EXTEND_STATS_EN
  ,
  output logic [15:0]        imm_count
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  imm_entry_t      mem_q [DEPTH];
  imm_entry_t      mem_d [DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] gen_ext;

  // Flags come from registered occupancy only, so no input reaches them
  // combinationally.
  assign bus.in_ready  = (cnt_q != CntW'(DEPTH));
  assign bus.out_valid = (cnt_q != '0);

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  imm_gen u_imm_gen (
    .instr_i   (bus.instr),
    .imm_src_i (bus.imm_src),
    .imm_ext_o (gen_ext)
  );

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = '{ext: gen_ext, kind: bus.imm_src};
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Storage is cleared too so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

  assign bus.imm_ext  = mem_q[rptr_q].ext;
  assign bus.imm_kind = mem_q[rptr_q].kind;

`ifdef IMM_EXTEND_STATS_EN
  logic [15:0] imm_count_q, imm_count_d;

  always_comb begin
    imm_count_d = imm_count_q;
    if (push && (imm_count_q != 16'hFFFF)) begin
      imm_count_d = imm_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_count_q <= '0;
    end else begin
      imm_count_q <= imm_count_d;
    end
  end

  assign imm_count = imm_count_q;
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed vectors, full-buffer
// back-pressure, mid-operation reset and randomized traffic against a queue model.
module tb_imm_extend_unit;

  localparam int DEPTH = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [33:0] exp_q[$];   // {kind, ext} in acceptance order
  logic [15:0] acc_cnt;

  imm_extend_unit_if bus ();

`ifdef IMM_EXTEND_STATS_EN
  logic [15:0] imm_count;
`endif

  imm_extend_unit #(
    .DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IMM_EXTEND_STATS_EN
    ,
    .imm_count (imm_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference immediate built with arithmetic on a signed copy of the word.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input logic [1:0] src);
    int s;
    logic [31:0] r;
    s = int'(ins);
    case (src)
      2'd0:    r = s >>> 20;
      2'd1:    r = ((s >>> 25) * 32) + int'(ins[11:7]);
      2'd2:    r = ((s >>> 31) * 4096) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                   + int'(ins[11:8]) * 2;
      default: r = ((s >>> 31) * 1048576) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                   + int'(ins[30:21]) * 2;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 34'(bus.out_valid), 34'd0);
    check({tag, "_in_ready"}, 34'(bus.in_ready), 34'd1);
    check({tag, "_imm_ext"}, 34'(bus.imm_ext), 34'd0);
    check({tag, "_imm_kind"}, 34'(bus.imm_kind), 34'd0);
`ifdef IMM_EXTEND_STATS_EN
    check({tag, "_imm_count"}, 34'(imm_count), 34'd0);
`endif
  endtask

  // Called between edges: drive, check against the model, take the edge, update model.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [1:0] src,
                       input logic ordy);
    logic acc, ret, exp_ov, exp_ir;
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.imm_src   = src;
    bus.out_ready = ordy;
    #1;
    exp_ov = (exp_q.size() != 0);
    exp_ir = (exp_q.size() != DEPTH);
    check("out_valid", 34'(bus.out_valid), 34'(exp_ov));
    check("in_ready", 34'(bus.in_ready), 34'(exp_ir));
    if (exp_ov) begin
      check("head_entry", {bus.imm_kind, bus.imm_ext}, exp_q[0]);
    end
`ifdef IMM_EXTEND_STATS_EN
    check("imm_count", 34'(imm_count), 34'(acc_cnt));
`endif
    acc = v && exp_ir;
    ret = ordy && exp_ov;
    @(posedge clk);
    #1;
    if (ret) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back({src, ref_imm(ins, src)});
      if (acc_cnt != 16'hFFFF) acc_cnt++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    acc_cnt  = '0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.imm_src   = '0;
    bus.out_ready = 1'b0;

    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, first one accepted on the first edge after reset.
    cycle(1'b1, 32'hFFF00093, 2'd0, 1'b0);
    check("vecI_valid", 34'(bus.out_valid), 34'd1);
    check("vecI", {bus.imm_kind, bus.imm_ext}, {2'd0, 32'hFFFFFFFF});
    cycle(1'b1, 32'h0020A423, 2'd1, 1'b1);
    check("vecS", {bus.imm_kind, bus.imm_ext}, {2'd1, 32'h00000008});
    cycle(1'b1, 32'hFE000EE3, 2'd2, 1'b1);
    check("vecB", {bus.imm_kind, bus.imm_ext}, {2'd2, 32'hFFFFFFFC});
    cycle(1'b1, 32'h001000EF, 2'd3, 1'b1);
    check("vecJ", {bus.imm_kind, bus.imm_ext}, {2'd3, 32'h00000800});
    cycle(1'b0, 32'h0, 2'd0, 1'b1);
    cycle(1'b0, 32'h0, 2'd0, 1'b1);

    // Three back-to-back pushes into a stalled buffer, then drain.
    cycle(1'b1, 32'h80000013, 2'd0, 1'b0);
    cycle(1'b1, 32'h7FF00013, 2'd0, 1'b0);
    check("full_in_ready", 34'(bus.in_ready), 34'd0);
    cycle(1'b1, 32'h12345678, 2'd1, 1'b0);
    cycle(1'b1, 32'h12345678, 2'd1, 1'b1);
    cycle(1'b0, 32'h0, 2'd0, 1'b1);
    cycle(1'b0, 32'h0, 2'd0, 1'b1);
    check("drained_in_ready", 34'(bus.in_ready), 34'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 2) != 0);
    end

    // Mid-operation reset with two entries buffered.
    cycle(1'b0, 32'h0, 2'd0, 1'b1);
    cycle(1'b0, 32'h0, 2'd0, 1'b1);
    cycle(1'b1, $urandom, 2'd2, 1'b0);
    cycle(1'b1, $urandom, 2'd3, 1'b0);
    check("prereset_count", 34'(exp_q.size()), 34'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    exp_q.delete();
    acc_cnt = '0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle($urandom_range(0, 1) != 0, $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
